// File: rtl/tt_sweep_capture.sv
// Truth-table sweeper: walks a 3-input DUT through all 8 input combinations and packs its outputs into an 8-bit hex code.
// Optional TT_SWEEP_CHECK_EN adds a comparator of the final code against an expected code.
module tt_sweep_capture #(
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic       out,
`ifdef TT_SWEEP_CHECK_EN
   input  logic [7:0] expected,
   output logic       match,
   output logic [7:0] mismatch_mask,
`endif
   output logic       in1,
   output logic       in2,
   output logic       in3,
   output logic       busy,
   output logic       done,
   output logic [7:0] code,
   output logic       code_valid
);

   typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYCLES - 1);

   state_t           state;
   logic [2:0]       idx;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         idx           <= 3'd0;
         cnt           <= '0;
         {in1,in2,in3} <= 3'b000;
         busy          <= 1'b0;
         done          <= 1'b0;
         code          <= 8'h00;
         code_valid    <= 1'b0;
`ifdef TT_SWEEP_CHECK_EN
         match         <= 1'b0;
         mismatch_mask <= 8'h00;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state         <= SETTLE;
                  idx           <= 3'd0;
                  cnt           <= '0;
                  code          <= 8'h00;
                  code_valid    <= 1'b0;
                  busy          <= 1'b1;
                  {in1,in2,in3} <= 3'b000;
`ifdef TT_SWEEP_CHECK_EN
                  match         <= 1'b0;
                  mismatch_mask <= 8'h00;
`endif
               end
            end
            SETTLE: begin
               // abort wins over a sample landing on the same edge
               if (abort) begin
                  state         <= IDLE;
                  busy          <= 1'b0;
                  cnt           <= '0;
                  idx           <= 3'd0;
                  {in1,in2,in3} <= 3'b000;
               end else if (cnt == LAST) begin
                  code[3'd7 - idx] <= out;
                  cnt              <= '0;
                  if (idx == 3'd7) begin
                     state         <= DONE;
                     {in1,in2,in3} <= 3'b000;
                  end else begin
                     idx           <= idx + 3'd1;
                     {in1,in2,in3} <= idx + 3'd1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               state         <= IDLE;
               done          <= 1'b1;
               code_valid    <= 1'b1;
               busy          <= 1'b0;
               idx           <= 3'd0;
               {in1,in2,in3} <= 3'b000;
`ifdef TT_SWEEP_CHECK_EN
               match         <= (code == expected);
               mismatch_mask <= code ^ expected;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Bench for tt_sweep_capture: two instances (settle 2 and settle 1) against an edge-count based model.
module tb_tt_sweep_capture;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic [7:0] fn0 = 8'h00, fn1 = 8'h00, exp_v = 8'h00;
   wire  [2:0] ins0, ins1;
   wire        b0, b1, d0, d1, v0, v1;
   wire  [7:0] c0, c1;
   logic       o0, o1;
`ifdef TT_SWEEP_CHECK_EN
   wire        m0, m1;
   wire  [7:0] k0, k1;
`endif

   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   // each DUT behaves as the gate whose hex identifier is fnX
   assign o0 = fn0[3'd7 - ins0];
   assign o1 = fn1[3'd7 - ins1];

   tt_sweep_capture #(.SETTLE_CYCLES(2), .CNT_W(8)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .out(o0),
`ifdef TT_SWEEP_CHECK_EN
      .expected(exp_v), .match(m0), .mismatch_mask(k0),
`endif
      .in1(ins0[2]), .in2(ins0[1]), .in3(ins0[0]),
      .busy(b0), .done(d0), .code(c0), .code_valid(v0));

   tt_sweep_capture #(.SETTLE_CYCLES(1), .CNT_W(8)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .out(o1),
`ifdef TT_SWEEP_CHECK_EN
      .expected(exp_v), .match(m1), .mismatch_mask(k1),
`endif
      .in1(ins1[2]), .in2(ins1[1]), .in3(ins1[0]),
      .busy(b1), .done(d1), .code(c1), .code_valid(v1));

   // model: e = edges since the accepting edge; all outputs follow from e and the settle time
   bit         act_m[2];
   int         e_m[2];
   logic [7:0] code_m[2];
   logic       cv_m[2], done_m[2], busy_m[2], match_m[2];
   logic [2:0] ins_m[2];
   logic [7:0] mask_m[2];

   function automatic int sc(input int k);
      return (k == 0) ? 2 : 1;
   endfunction

   task automatic mreset();
      for (int k = 0; k < 2; k++) begin
         act_m[k] = 0; e_m[k] = 0; code_m[k] = 8'h00; cv_m[k] = 0;
         done_m[k] = 0; busy_m[k] = 0; ins_m[k] = 3'd0; match_m[k] = 0; mask_m[k] = 8'h00;
      end
   endtask

   task automatic mstep(input int k, input logic [7:0] f);
      int s, i;
      s = sc(k);
      done_m[k] = 0;
      if (!act_m[k]) begin
         if (start) begin
            act_m[k] = 1; e_m[k] = 0; code_m[k] = 8'h00; cv_m[k] = 0;
            busy_m[k] = 1; ins_m[k] = 3'd0; match_m[k] = 0; mask_m[k] = 8'h00;
         end
      end else begin
         e_m[k]++;
         if (e_m[k] <= 8 * s) begin
            if (abort) begin
               act_m[k] = 0; busy_m[k] = 0; ins_m[k] = 3'd0;
            end else if (e_m[k] % s == 0) begin
               i = e_m[k] / s - 1;
               code_m[k][7 - i] = f[7 - i];
               ins_m[k] = (e_m[k] < 8 * s) ? 3'(e_m[k] / s) : 3'd0;
            end
         end else begin
            done_m[k] = 1; cv_m[k] = 1; busy_m[k] = 0; act_m[k] = 0; ins_m[k] = 3'd0;
            match_m[k] = (code_m[k] == exp_v);
            mask_m[k] = code_m[k] ^ exp_v;
         end
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) mreset();
      else begin
         mstep(0, fn0);
         mstep(1, fn1);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("busy0", 32'(b0), 32'(busy_m[0]));  chk("busy1", 32'(b1), 32'(busy_m[1]));
      chk("done0", 32'(d0), 32'(done_m[0]));  chk("done1", 32'(d1), 32'(done_m[1]));
      chk("cv0", 32'(v0), 32'(cv_m[0]));      chk("cv1", 32'(v1), 32'(cv_m[1]));
      chk("code0", 32'(c0), 32'(code_m[0]));  chk("code1", 32'(c1), 32'(code_m[1]));
      chk("ins0", 32'(ins0), 32'(ins_m[0]));  chk("ins1", 32'(ins1), 32'(ins_m[1]));
`ifdef TT_SWEEP_CHECK_EN
      chk("match0", 32'(m0), 32'(match_m[0])); chk("mask0", 32'(k0), 32'(mask_m[0]));
      chk("match1", 32'(m1), 32'(match_m[1])); chk("mask1", 32'(k1), 32'(mask_m[1]));
`endif
   end

   int n0, n1, nd0, nd1;

   // pulse start, then watch 24 edges; optional abort before edge ab and restart pulse before edge rs+1
   task automatic sweep(input int ab, input int rs);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      n0 = -1; n1 = -1; nd0 = 0; nd1 = 0;
      for (int n = 1; n <= 24; n++) begin
         @(negedge clk);
         if (d0) begin nd0++; if (n0 < 0) n0 = n; end
         if (d1) begin nd1++; if (n1 < 0) n1 = n; end
         abort = (ab != 0 && n == ab - 1);
         start = (rs != 0 && n == rs);
      end
      abort = 1'b0; start = 1'b0;
   endtask

   initial begin
      mreset();
      repeat (3) @(negedge clk);
      chk("rst_code", 32'(c0), 32'h00);
      chk("rst_busy", 32'(b0), 32'h0);
      rst_n = 1'b1;

      // 0x53 gate on the settle-2 unit, out=in1 (0x0F) on the settle-1 unit, restart pulse while busy
      fn0 = 8'h53; fn1 = 8'h0F;
      sweep(0, 3);
      chk("lat0", 32'(n0), 32'd17);
      chk("lat1", 32'(n1), 32'd9);
      chk("ndone0", 32'(nd0), 32'd1);
      chk("ndone1", 32'(nd1), 32'd1);
      chk("code53", 32'(c0), 32'h53);
      chk("code0F", 32'(c1), 32'h0F);
      chk("cv_after", 32'(v0), 32'h1);
      chk("busy_after", 32'(b0), 32'h0);

      fn0 = 8'h00; fn1 = 8'hFF;
      sweep(0, 0);
      chk("const0", 32'(c0), 32'h00);
      chk("const1", 32'(c1), 32'hFF);
      fn0 = 8'hFF; fn1 = 8'h00;
      sweep(0, 0);
      chk("const1b", 32'(c0), 32'hFF);
      chk("const0b", 32'(c1), 32'h00);

      // abort on the 5th settle cycle
      fn0 = 8'h53;
      sweep(5, 0);
      chk("ab_done", 32'(nd0), 32'd0);
      chk("ab_cv", 32'(v0), 32'h0);
      chk("ab_busy", 32'(b0), 32'h0);
      chk("ab_ins", 32'(ins0), 32'h0);
      sweep(0, 0);
      chk("ab_fresh", 32'(c0), 32'h53);

      // asynchronous reset between edges mid-sweep
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (6) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out", {19'd0, b0, d0, v0, ins0, c0}, 32'h0);
      chk("arst_busy1", 32'(b1), 32'h0);
      @(negedge clk); rst_n = 1'b1;
      fn0 = 8'hA6; fn1 = 8'h3C;
      sweep(0, 0);
      chk("post_rst0", 32'(c0), 32'hA6);
      chk("post_rst1", 32'(c1), 32'h3C);

`ifdef TT_SWEEP_CHECK_EN
      fn0 = 8'h53; exp_v = 8'h53;
      sweep(0, 0);
      chk("feat_m1", 32'(m0), 32'h1);
      chk("feat_k0", 32'(k0), 32'h00);
      exp_v = 8'h52;
      sweep(0, 0);
      chk("feat_m0", 32'(m0), 32'h0);
      chk("feat_k1", 32'(k0), 32'h01);
`endif

      // random traffic: starts, aborts and gate changes at arbitrary times
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         start = ($urandom_range(0, 7) == 0);
         abort = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 39) == 0) fn0 = 8'($urandom);
         if ($urandom_range(0, 39) == 0) fn1 = 8'($urandom);
         if ($urandom_range(0, 19) == 0) exp_v = 8'($urandom);
      end
      start = 1'b0; abort = 1'b0;
      repeat (25) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
